// File: rtl/gb_sound_pkg.sv
// Shared constants and helpers for the sound frame sequencer.
// Holds step width, per-step strobe masks (bit n = step n) and decode.
package gb_sound_pkg;

   localparam int unsigned FS_STEP_W      = 3;
   localparam int unsigned FS_DEFAULT_DIV = 8192;

   localparam logic [7:0] FS_LEN_MASK   = 8'b0101_0101;
   localparam logic [7:0] FS_SWEEP_MASK = 8'b0100_0100;
   localparam logic [7:0] FS_ENV_MASK   = 8'b1000_0000;

   typedef struct packed {
      logic len;
      logic sweep;
      logic env;
   } fs_strobe_t;

   function automatic fs_strobe_t fs_decode(input logic [FS_STEP_W-1:0] s);
      fs_strobe_t r;
      r.len   = FS_LEN_MASK[s];
      r.sweep = FS_SWEEP_MASK[s];
      r.env   = FS_ENV_MASK[s];
      return r;
   endfunction

endpackage

// File: rtl/fs_prescaler.sv
// Frame-tick prescaler: counts 0..DIV-1, tc_o high while count is DIV-1.
// Ports: clk_i, rst_ni (async low), clr_i (sync clear), en_i, tc_o.
module fs_prescaler
   import gb_sound_pkg::*;
#(
   parameter int unsigned DIV = FS_DEFAULT_DIV,
   parameter int unsigned W   = $clog2(DIV)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         tc_q, tc_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_q ? '0 : cnt_q + W'(1);
      end
      // Flag is precomputed so it is a flop, aligned with cnt_q == LAST.
      tc_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/frame_sequencer.sv
// 512 Hz frame sequencer: 8-step schedule of length/sweep/envelope strobes.
// Ports: clk, rst_n, power_en, div_reset, [tick_src], len_clk, sweep_clk,
// env_clk, step. FRAME_SEQUENCER_EXT_TICK_EN: tick from tick_src falling edge.
module frame_sequencer
   import gb_sound_pkg::*;
#(
   parameter int unsigned CLK_DIV = FS_DEFAULT_DIV
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 power_en,
   input  logic                 div_reset,
`ifdef FRAME_SEQUENCER_EXT_TICK_EN
   input  logic                 tick_src,
`endif
   output logic                 len_clk,
   output logic                 sweep_clk,
   output logic                 env_clk,
   output logic [FS_STEP_W-1:0] step
);

   if (CLK_DIV < 2 || CLK_DIV > 65536) begin : g_bad_div
      $error("CLK_DIV out of range");
   end

   logic tick;

`ifdef FRAME_SEQUENCER_EXT_TICK_EN
   logic src_q;

   // A DIV write only forgets the history; a later 1->0 still ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q <= 1'b0;
      end else begin
         src_q <= div_reset ? 1'b0 : tick_src;
      end
   end

   assign tick = src_q & ~tick_src;
`else
   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   fs_prescaler #(
      .DIV (CLK_DIV),
      .W   (CNT_W)
   ) u_pre (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .clr_i  (~power_en | div_reset),
      .en_i   (power_en),
      .tc_o   (tick)
   );
`endif

   logic [FS_STEP_W-1:0] step_q;
   fs_strobe_t           str_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q <= '0;
         str_q  <= '0;
      end else if (!power_en) begin
         step_q <= '0;
         str_q  <= '0;
      end else if (div_reset) begin
         str_q  <= '0;
      end else if (tick) begin
         step_q <= step_q + FS_STEP_W'(1);
         str_q  <= fs_decode(step_q);
      end else begin
         str_q  <= '0;
      end
   end

   assign len_clk   = str_q.len;
   assign sweep_clk = str_q.sweep;
   assign env_clk   = str_q.env;
   assign step      = step_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: two instances (CLK_DIV=4 and default)
// against a cycle model, plus literal checks of the schedule.
module tb_frame_sequencer;

   logic clk = 1'b0;
   logic rst_n, pe, dr, ts;

   logic       len0, sw0, env0, len1, sw1, env1;
   logic [2:0] step0, step1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   frame_sequencer #(.CLK_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .power_en  (pe),
      .div_reset (dr),
`ifdef FRAME_SEQUENCER_EXT_TICK_EN
      .tick_src  (ts),
`endif
      .len_clk   (len0),
      .sweep_clk (sw0),
      .env_clk   (env0),
      .step      (step0)
   );

   frame_sequencer dut_big (
      .clk       (clk),
      .rst_n     (rst_n),
      .power_en  (pe),
      .div_reset (dr),
`ifdef FRAME_SEQUENCER_EXT_TICK_EN
      .tick_src  (ts),
`endif
      .len_clk   (len1),
      .sweep_clk (sw1),
      .env_clk   (env1),
      .step      (step1)
   );

   // Model: age = enabled cycles since last restart; tick when age hits div.
   int m_div[2] = '{4, 8192};
   int m_age[2] = '{0, 0};
   int m_step[2] = '{0, 0};
   int m_len[2] = '{0, 0};
   int m_sw[2] = '{0, 0};
   int m_env[2] = '{0, 0};
   int m_prev = 0;

   always @(posedge clk or negedge rst_n) begin
      bit tk_ext, tk;
      if (!rst_n) begin
         m_prev = 0;
         for (int i = 0; i < 2; i++) begin
            m_age[i] = 0; m_step[i] = 0;
            m_len[i] = 0; m_sw[i] = 0; m_env[i] = 0;
         end
      end else begin
         tk_ext = (m_prev == 1) && (ts == 1'b0);
         m_prev = dr ? 0 : int'(ts);
         for (int i = 0; i < 2; i++) begin
            m_len[i] = 0; m_sw[i] = 0; m_env[i] = 0;
            if (!pe) begin
               m_age[i] = 0;
               m_step[i] = 0;
            end else if (dr) begin
               m_age[i] = 0;
            end else begin
`ifdef FRAME_SEQUENCER_EXT_TICK_EN
               tk = tk_ext;
`else
               m_age[i] = m_age[i] + 1;
               tk = (m_age[i] == m_div[i]);
               if (tk) m_age[i] = 0;
`endif
               if (tk) begin
                  m_len[i] = (m_step[i] % 2 == 0) ? 1 : 0;
                  m_sw[i]  = (m_step[i] % 4 == 2) ? 1 : 0;
                  m_env[i] = (m_step[i] == 7) ? 1 : 0;
                  m_step[i] = (m_step[i] + 1) % 8;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      chk("len0", 32'(len0), m_len[0]);
      chk("sweep0", 32'(sw0), m_sw[0]);
      chk("env0", 32'(env0), m_env[0]);
      chk("step0", 32'(step0), m_step[0]);
      chk("len1", 32'(len1), m_len[1]);
      chk("sweep1", 32'(sw1), m_sw[1]);
      chk("env1", 32'(env1), m_env[1]);
      chk("step1", 32'(step1), m_step[1]);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int n_len, n_sw, n_env, env_at, first;

   initial begin
      rst_n = 1'b1; pe = 1'b0; dr = 1'b0; ts = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_step", 32'(step0), 0);
      chk("rst_len", 32'(len0), 0);
      chk("rst_sweep", 32'(sw0), 0);
      chk("rst_env", 32'(env0), 0);
      tick(3);
      rst_n = 1'b1; pe = 1'b1;
`ifndef FRAME_SEQUENCER_EXT_TICK_EN
      // Full schedule at CLK_DIV=4.
      n_len = 0; n_sw = 0; n_env = 0; env_at = 0; first = 0;
      for (int n = 1; n <= 32; n++) begin
         tick(1);
         if (len0) begin
            n_len++;
            if (first == 0) first = n;
         end
         if (sw0) n_sw++;
         if (env0) begin
            n_env++;
            env_at = n;
         end
      end
      chk("first_len", first, 4);
      chk("len_count", n_len, 4);
      chk("sweep_count", n_sw, 2);
      chk("env_count", n_env, 1);
      chk("env_at", env_at, 32);
      chk("wrap_step", 32'(step0), 0);
      // Power drop at step 3.
      tick(14);
      chk("pre_drop_step", 32'(step0), 3);
      pe = 1'b0;
      for (int n = 0; n < 6; n++) begin
         tick(1);
         chk("off_step", 32'(step0), 0);
         chk("off_strobes", 32'({len0, sw0, env0}), 0);
      end
      pe = 1'b1;
      tick(3);
      chk("rise_early", 32'(len0), 0);
      tick(1);
      chk("rise_len", 32'(len0), 1);
      chk("rise_sweep", 32'(sw0), 0);
      chk("rise_step", 32'(step0), 1);
      // div_reset on the TC edge of step 2.
      tick(4);
      tick(3);
      dr = 1'b1;
      tick(1);
      dr = 1'b0;
      chk("dr_strobes", 32'({len0, sw0, env0}), 0);
      chk("dr_step", 32'(step0), 2);
      tick(3);
      chk("dr_early", 32'(len0), 0);
      tick(1);
      chk("dr_len", 32'(len0), 1);
      chk("dr_sweep", 32'(sw0), 1);
      chk("dr_after_step", 32'(step0), 3);
      // Async reset at step 5, cnt 2.
      tick(8);
      tick(2);
      chk("pre_rst_step", 32'(step0), 5);
      rst_n = 1'b0;
      #1;
      chk("arst_step", 32'(step0), 0);
      chk("arst_strobes", 32'({len0, sw0, env0}), 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk("arst_early", 32'(len0), 0);
      tick(1);
      chk("arst_len", 32'(len0), 1);
      chk("arst_after", 32'(step0), 1);
`else
      // tick_src toggled every 3 cycles: 6 falling edges.
      for (int k = 0; k < 12; k++) begin
         tick(3);
         ts = ~ts;
      end
      tick(2);
      chk("ext_steps", 32'(step0), 6);
      chk("ext_steps_big", 32'(step1), 6);
      ts = 1'b1;
      tick(2);
      dr = 1'b1;
      tick(1);
      dr = 1'b0;
      tick(1);
      ts = 1'b0;
      tick(1);
      chk("ext_dr_len", 32'(len0), 1);
      chk("ext_dr_sweep", 32'(sw0), 1);
      chk("ext_dr_step", 32'(step0), 7);
`endif
      // Randomized traffic checked by the model.
      for (int n = 0; n < 3000; n++) begin
         pe = ($urandom_range(15) != 0);
         dr = ($urandom_range(31) == 0);
         if ($urandom_range(3) == 0) ts = ~ts;
         tick(1);
      end
      pe = 1'b1; dr = 1'b0;
`ifndef FRAME_SEQUENCER_EXT_TICK_EN
      // Default divider over one full schedule.
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      n_len = 0; n_sw = 0; n_env = 0; env_at = 0;
      for (int n = 1; n <= 65536; n++) begin
         tick(1);
         if (len1) n_len++;
         if (sw1) n_sw++;
         if (env1) begin
            n_env++;
            env_at = n;
         end
      end
      chk("big_len", n_len, 4);
      chk("big_sweep", n_sw, 2);
      chk("big_env", n_env, 1);
      chk("big_env_at", env_at, 65536);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
